fp_align_pipe: RTL and testbench

Pipelined, parametrised mantissa-alignment stage for the floating-point adder datapath, processing `N_LANES` independent operand pairs per transaction. Each lane takes two raw operands (biased exponent plus stored fraction) and does the following:
- orders the two operands by magnitude;
- handles the denormal hidden bit and effective exponent;
- right-shifts the smaller mantissa by the exponent difference, producing guard/round/sticky bits.

The block sits between operand unpack and the mantissa add/normalise stage. It uses a valid/ready handshake with full backpressure.

---
 rtl/fp_align_pipe_if.sv | 33 +++
 rtl/fp_align_pipe.sv | 118 +++++++++++
 tb/tb_fp_align_pipe.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_align_pipe_if.sv
// Handshake and operand/result bundle for the FP mantissa-alignment stage.
// The master drives operands and consumes results; the slave is the pipeline.
interface fp_align_pipe_if #(
  parameter int N_LANES = 2,
  parameter int EXP_W   = 11,
  parameter int MAN_W   = 53,
  parameter int TAG_W   = 4
);
  logic                          i_valid;
  logic                          i_ready;
  logic [TAG_W-1:0]              i_tag;
  logic [N_LANES*EXP_W-1:0]      i_a_exp;
  logic [N_LANES*EXP_W-1:0]      i_b_exp;
  logic [N_LANES*(MAN_W-1)-1:0]  i_a_frac;
  logic [N_LANES*(MAN_W-1)-1:0]  i_b_frac;
  logic                          o_valid;
  logic                          o_ready;
  logic [TAG_W-1:0]              o_tag;
  logic [N_LANES*EXP_W-1:0]      o_exp;
  logic [N_LANES*(MAN_W+4)-1:0]  o_large_man;
  logic [N_LANES*(MAN_W+4)-1:0]  o_small_man;
  logic [N_LANES-1:0]            o_swap;

  modport master (
    output i_valid, i_tag, i_a_exp, i_b_exp, i_a_frac, i_b_frac, o_ready,
    input  i_ready, o_valid, o_tag, o_exp, o_large_man, o_small_man, o_swap
  );

  modport slave (
    input  i_valid, i_tag, i_a_exp, i_b_exp, i_a_frac, i_b_frac, o_ready,
    output i_ready, o_valid, o_tag, o_exp, o_large_man, o_small_man, o_swap
  );
endinterface

// File: rtl/fp_align_pipe.sv
// Two-stage mantissa alignment for the FP adder: compare/swap, then shift with
// guard/round/sticky generation. Lanes are independent; the handshake is shared.
module fp_align_pipe #(
  parameter int N_LANES = 2,
  parameter int EXP_W   = 11,
  parameter int MAN_W   = 53,
  parameter int TAG_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  fp_align_pipe_if.slave   bus
);
  localparam int FRAC_W = MAN_W - 1;
  localparam int EXT_W  = MAN_W + 2;
  localparam int OUT_W  = MAN_W + 4;
  localparam logic [EXP_W-1:0] SA_SAT = EXP_W'(EXT_W);

  logic v1, v2;
  logic adv1, adv2, load1, load2;

  assign adv2        = !v2 || bus.o_ready;
  assign adv1        = !v1 || adv2;
  assign bus.i_ready = adv1;
  assign load1       = bus.i_valid && adv1;
  assign load2       = v1 && adv2;
  assign bus.o_valid = v2;

  logic [MAN_W-1:0]   c1_man_l [N_LANES];
  logic [MAN_W-1:0]   c1_man_s [N_LANES];
  logic [EXP_W-1:0]   c1_eff   [N_LANES];
  logic [EXP_W-1:0]   c1_sa    [N_LANES];
  logic [N_LANES-1:0] c1_swap;

  logic [MAN_W-1:0]   s1_man_l [N_LANES];
  logic [MAN_W-1:0]   s1_man_s [N_LANES];
  logic [EXP_W-1:0]   s1_eff   [N_LANES];
  logic [EXP_W-1:0]   s1_sa    [N_LANES];
  logic [N_LANES-1:0] s1_swap;
  logic [TAG_W-1:0]   s1_tag;

  logic [N_LANES*EXP_W-1:0] c2_exp;
  logic [N_LANES*OUT_W-1:0] c2_large;
  logic [N_LANES*OUT_W-1:0] c2_small;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic [EXP_W-1:0] exp_a, exp_b, eff_a, eff_b;
    logic [MAN_W-1:0] man_a, man_b;
    logic             a_big;
    logic [EXT_W-1:0] ext, mask, sh;
    logic             in_range, sticky;

    // Denormals behave as exponent 1 with a cleared hidden bit.
    assign exp_a = bus.i_a_exp[k*EXP_W +: EXP_W];
    assign exp_b = bus.i_b_exp[k*EXP_W +: EXP_W];
    assign eff_a = (exp_a == '0) ? EXP_W'(1) : exp_a;
    assign eff_b = (exp_b == '0) ? EXP_W'(1) : exp_b;
    assign man_a = {exp_a != '0, bus.i_a_frac[k*FRAC_W +: FRAC_W]};
    assign man_b = {exp_b != '0, bus.i_b_frac[k*FRAC_W +: FRAC_W]};
    assign a_big = (eff_a > eff_b) || ((eff_a == eff_b) && (man_a >= man_b));

    assign c1_man_l[k] = a_big ? man_a : man_b;
    assign c1_man_s[k] = a_big ? man_b : man_a;
    assign c1_eff[k]   = a_big ? eff_a : eff_b;
    assign c1_sa[k]    = a_big ? (eff_a - eff_b) : (eff_b - eff_a);
    assign c1_swap[k]  = !a_big;

    // Beyond the extended width every bit of the small mantissa is shifted out.
    assign ext      = {s1_man_s[k], 2'b00};
    assign in_range = s1_sa[k] < SA_SAT;
    assign mask     = ~({EXT_W{1'b1}} << s1_sa[k]);
    assign sh       = in_range ? (ext >> s1_sa[k]) : '0;
    assign sticky   = in_range ? |(ext & mask) : |s1_man_s[k];

    assign c2_small[k*OUT_W +: OUT_W] = {1'b0, sh, sticky};
    assign c2_large[k*OUT_W +: OUT_W] = {1'b0, s1_man_l[k], 3'b000};
    assign c2_exp[k*EXP_W +: EXP_W]   = s1_eff[k];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1              <= 1'b0;
      v2              <= 1'b0;
      s1_tag          <= '0;
      s1_swap         <= '0;
      for (int k = 0; k < N_LANES; k++) begin
        s1_man_l[k] <= '0;
        s1_man_s[k] <= '0;
        s1_eff[k]   <= '0;
        s1_sa[k]    <= '0;
      end
      bus.o_tag       <= '0;
      bus.o_exp       <= '0;
      bus.o_large_man <= '0;
      bus.o_small_man <= '0;
      bus.o_swap      <= '0;
    end else begin
      if (adv1) v1 <= bus.i_valid;
      if (adv2) v2 <= v1;
      if (load1) begin
        s1_tag  <= bus.i_tag;
        s1_swap <= c1_swap;
        for (int k = 0; k < N_LANES; k++) begin
          s1_man_l[k] <= c1_man_l[k];
          s1_man_s[k] <= c1_man_s[k];
          s1_eff[k]   <= c1_eff[k];
          s1_sa[k]    <= c1_sa[k];
        end
      end
      if (load2) begin
        bus.o_tag       <= s1_tag;
        bus.o_exp       <= c2_exp;
        bus.o_large_man <= c2_large;
        bus.o_small_man <= c2_small;
        bus.o_swap      <= s1_swap;
      end
    end
  end
endmodule

// File: tb/tb_fp_align_pipe.sv
// Scoreboard bench for fp_align_pipe: directed operand cases, backpressure,
// mid-stream reset and a randomized handshake phase.
module tb_fp_align_pipe;
  localparam int N_LANES = 2;
  localparam int EXP_W   = 11;
  localparam int MAN_W   = 53;
  localparam int TAG_W   = 4;
  localparam int FRAC_W  = MAN_W - 1;
  localparam int LW      = MAN_W + 4;

  typedef struct {
    logic [TAG_W-1:0]         tag;
    logic [N_LANES*EXP_W-1:0] ex;
    logic [N_LANES*LW-1:0]    lg;
    logic [N_LANES*LW-1:0]    sm;
    logic [N_LANES-1:0]       sw;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;
  bit   acc;
  exp_t pending;
  exp_t sb[$];

  fp_align_pipe_if #(.N_LANES(N_LANES), .EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

  fp_align_pipe #(.N_LANES(N_LANES), .EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic exp_t mk(input logic [TAG_W-1:0] tag,
                              input logic [EXP_W-1:0] e0, input logic [63:0] l0, s0, input logic w0,
                              input logic [EXP_W-1:0] e1, input logic [63:0] l1, s1, input logic w1);
    exp_t r;
    r.tag = tag;
    r.ex  = {e1, e0};
    r.lg  = {l1[LW-1:0], l0[LW-1:0]};
    r.sm  = {s1[LW-1:0], s0[LW-1:0]};
    r.sw  = {w1, w0};
    return r;
  endfunction

  // Reference behaviour of one lane, written from the arithmetic definition.
  task automatic model_lane(input logic [EXP_W-1:0] ae, input logic [FRAC_W-1:0] af,
                            input logic [EXP_W-1:0] be, input logic [FRAC_W-1:0] bf,
                            output logic [EXP_W-1:0] oe, output logic [LW-1:0] lg,
                            output logic [LW-1:0] sm, output logic sw);
    int ea, eb, d;
    logic [63:0] ma, mb, mhi, mlo, ext, sh;
    logic s;
    ea = (ae == 0) ? 1 : int'(ae);
    eb = (be == 0) ? 1 : int'(be);
    ma = {11'd0, (ae != 0), af};
    mb = {11'd0, (be != 0), bf};
    sw = !((ea > eb) || (ea == eb && ma >= mb));
    mhi = sw ? mb : ma;
    mlo = sw ? ma : mb;
    d   = sw ? (eb - ea) : (ea - eb);
    oe  = EXP_W'(sw ? eb : ea);
    ext = mlo * 4;
    s   = 1'b0;
    if (d >= MAN_W + 2) begin
      sh = 0;
      s  = (mlo != 0);
    end else begin
      sh = ext >> d;
      for (int i = 0; i < d; i++) if (ext[i]) s = 1'b1;
    end
    sm = LW'(sh * 2 + {63'd0, s});
    lg = LW'(mhi * 8);
  endtask

  task automatic set_lane(input int k, input logic [EXP_W-1:0] ae, input logic [FRAC_W-1:0] af,
                          input logic [EXP_W-1:0] be, input logic [FRAC_W-1:0] bf);
    bus.i_a_exp[k*EXP_W +: EXP_W]    = ae;
    bus.i_a_frac[k*FRAC_W +: FRAC_W] = af;
    bus.i_b_exp[k*EXP_W +: EXP_W]    = be;
    bus.i_b_frac[k*FRAC_W +: FRAC_W] = bf;
  endtask

  task automatic drive_rand(input logic [TAG_W-1:0] tag);
    logic [EXP_W-1:0] ae, be, oe;
    logic [FRAC_W-1:0] af, bf;
    logic [LW-1:0] lg, sm;
    logic sw;
    bus.i_tag   = tag;
    pending.tag = tag;
    for (int k = 0; k < N_LANES; k++) begin
      ae = $urandom_range(0, 1) ? EXP_W'($urandom_range(0, 70)) : EXP_W'($urandom_range(0, 2047));
      be = $urandom_range(0, 1) ? EXP_W'($urandom_range(0, 70)) : EXP_W'($urandom_range(0, 2047));
      af = ($urandom_range(0, 3) == 0) ? '0 : FRAC_W'({$urandom, $urandom});
      bf = ($urandom_range(0, 3) == 0) ? '0 : FRAC_W'({$urandom, $urandom});
      set_lane(k, ae, af, be, bf);
      model_lane(ae, af, be, bf, oe, lg, sm, sw);
      pending.ex[k*EXP_W +: EXP_W] = oe;
      pending.lg[k*LW +: LW]       = lg;
      pending.sm[k*LW +: LW]       = sm;
      pending.sw[k]                = sw;
    end
  endtask

  // One clock: compare/push at the falling edge, return just after the rising edge.
  task automatic tick();
    exp_t e;
    acc = 1'b0;
    @(negedge clk);
    if (bus.o_valid && bus.o_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("tag", 64'(bus.o_tag), 64'(e.tag));
        chk("swap", 64'(bus.o_swap), 64'(e.sw));
        for (int k = 0; k < N_LANES; k++) begin
          chk($sformatf("exp%0d", k), 64'(bus.o_exp[k*EXP_W +: EXP_W]), 64'(e.ex[k*EXP_W +: EXP_W]));
          chk($sformatf("large%0d", k), 64'(bus.o_large_man[k*LW +: LW]), 64'(e.lg[k*LW +: LW]));
          chk($sformatf("small%0d", k), 64'(bus.o_small_man[k*LW +: LW]), 64'(e.sm[k*LW +: LW]));
        end
      end
    end
    if (bus.i_valid && bus.i_ready) begin
      sb.push_back(pending);
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send();
    bus.i_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) tick();
    chk("send_accept", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
    tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [TAG_W-1:0] held_tag;
  logic [LW-1:0]    held_lg, held_sm;
  int               n_acc;

  initial begin
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_tag   = '0;
    bus.i_a_exp = '0;
    bus.i_b_exp = '0;
    bus.i_a_frac = '0;
    bus.i_b_frac = '0;
    bus.o_ready = 1'b0;
    pending     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    #13;
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_i_ready", 64'(bus.i_ready), 64'd1);
    chk("rst_o_large", 64'(bus.o_large_man[LW-1:0]), 64'd0);
    chk("rst_o_tag", 64'(bus.o_tag), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.o_ready = 1'b1;

    // Plan vectors: lane0 exponent diff 1, lane1 denormal vs normal with swap.
    set_lane(0, 11'h400, 0, 11'h3FF, 0);
    set_lane(1, 11'h000, 1, 11'h001, 5);
    bus.i_tag = 4'd1;
    pending = mk(1, 11'h400, 64'd1 << 55, 64'd1 << 54, 0,
                    11'h001, (64'd1 << 55) | (64'd5 << 3), 64'd8, 1);
    send();
    bus.i_valid = 1'b0;
    chk("lat_valid_lo", 64'(bus.o_valid), 64'd0);
    tick();
    chk("lat_valid_hi", 64'(bus.o_valid), 64'd1);
    tick();

    // sa=4 with sticky; saturated shift with and without fraction bits.
    set_lane(0, 11'd5, 0, 11'd1, 1);
    set_lane(1, 11'h7FE, 0, 11'd1, 1);
    bus.i_tag = 4'd2;
    pending = mk(2, 11'd5, 64'd1 << 55, (64'd1 << 51) | 64'd1, 0,
                    11'h7FE, 64'd1 << 55, 64'd1, 0);
    send();
    set_lane(0, 11'h7FE, 0, 11'd1, 0);
    set_lane(1, 11'd0, 0, 11'd0, 0);
    bus.i_tag = 4'd3;
    pending = mk(3, 11'h7FE, 64'd1 << 55, 64'd1, 0, 11'd1, 64'd0, 64'd0, 0);
    send();
    // sa = MAN_W+1 puts the MSB in R; sa = MAN_W+2 leaves only sticky.
    set_lane(0, 11'd56, 0, 11'd2, 0);
    set_lane(1, 11'd2, 0, 11'd57, 0);
    bus.i_tag = 4'd4;
    pending = mk(4, 11'd56, 64'd1 << 55, 64'd2, 0, 11'd57, 64'd1 << 55, 64'd1, 1);
    send();
    // Both denormal: ordered by mantissa; equal operands keep a.
    set_lane(0, 11'd0, 3, 11'd0, 7);
    set_lane(1, 11'd0, 9, 11'd0, 9);
    bus.i_tag = 4'd5;
    pending = mk(5, 11'd1, 64'd56, 64'd24, 1, 11'd1, 64'd72, 64'd72, 0);
    send();
    drain();

    // Throughput: back-to-back accepts with o_ready high.
    n_acc = 0;
    bus.i_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_rand(TAG_W'(i));
      tick();
      if (acc) n_acc++;
    end
    chk("thru_accepts", 64'(n_acc), 64'd8);
    drain();

    // Backpressure: two accepted, third stalls, outputs frozen.
    bus.o_ready = 1'b0;
    drive_rand(4'd1); send();
    drive_rand(4'd2); send();
    drive_rand(4'd3);
    chk("bp_i_ready_lo", 64'(bus.i_ready), 64'd0);
    chk("bp_o_tag", 64'(bus.o_tag), 64'd1);
    held_tag = bus.o_tag;
    held_lg  = bus.o_large_man[LW-1:0];
    held_sm  = bus.o_small_man[LW-1:0];
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_no_accept", 64'(acc), 64'd0);
      chk("bp_hold_tag", 64'(bus.o_tag), 64'(held_tag));
      chk("bp_hold_large", 64'(bus.o_large_man[LW-1:0]), 64'(held_lg));
      chk("bp_hold_small", 64'(bus.o_small_man[LW-1:0]), 64'(held_sm));
    end
    bus.o_ready = 1'b1;
    #1;
    chk("full_i_ready", 64'(bus.i_ready), 64'd1);
    tick();
    chk("full_accept", 64'(acc), 64'd1);
    bus.i_valid = 1'b0;
    chk("full_occupancy", 64'(sb.size()), 64'd2);
    drain();

    // Reset mid-stream with both stages full.
    bus.o_ready = 1'b0;
    drive_rand(4'd6); send();
    drive_rand(4'd7); send();
    bus.i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("mrst_i_ready", 64'(bus.i_ready), 64'd1);
    chk("mrst_o_tag", 64'(bus.o_tag), 64'd0);
    chk("mrst_o_exp", 64'(bus.o_exp), 64'd0);
    chk("mrst_o_large", 64'(bus.o_large_man[LW-1:0]), 64'd0);
    chk("mrst_o_small", 64'(bus.o_small_man[LW-1:0]), 64'd0);
    chk("mrst_o_swap", 64'(bus.o_swap), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.o_ready = 1'b1;
    drive_rand(4'd9);
    send();
    bus.i_valid = 1'b0;
    chk("post_rst_valid_lo", 64'(bus.o_valid), 64'd0);
    tick();
    chk("post_rst_valid_hi", 64'(bus.o_valid), 64'd1);
    chk("post_rst_tag", 64'(bus.o_tag), 64'd9);
    drain();

    // Random valid/ready traffic.
    for (int i = 0; i < 60; i++) begin
      drive_rand(TAG_W'(i));
      bus.i_valid = ($urandom_range(0, 3) != 0);
      bus.o_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
